conv_inst_sched: RTL and testbench
==================================

Name: conv_inst_sched

Overview:
- Instruction scheduler sitting in front of the convolution controller.
- Buffers layer-level convolution instructions in a small FIFO.
- Expands each instruction into one sub-op per group of InputDim input channels, and drives the controller's four weight addresses, four data addresses, picture size, conv_first and inst_tag.
- Issues a sub-op by toggling inst_tag, then waits for the controller's completion pulse before issuing the next.

Parameters:
AddrWidth, 32, width of all weight/data addresses and strides
PictWidth, 9, width of picture size field
GroupWidth, 8, width of the channel-group count field
KernelSize, 9, words per kernel per channel (weight channel stride)
InputDim, 4, channels per sub-op (fixed 4; address lanes 0..3)
FifoDepth, 4, instruction FIFO entries (power of two, >=2)
FifoAw, 2, log2(FifoDepth)

Ports:
Clk  in  1  single clock, rising edge
Rst  in  1  asynchronous, active-low reset
inst_valid_in  in  1  instruction push request
inst_ready_out  out  1  FIFO not full; push accepted when valid&&ready
inst_wbase_in  in  AddrWidth  weight base address
inst_dbase_in  in  AddrWidth  data base address
inst_dstride_in  in  AddrWidth  data channel stride (words per input channel)
inst_pict_in  in  PictWidth  picture size (square)
inst_groups_in  in  GroupWidth  number of channel groups, 0 treated as 1
conv_done_in  in  1  one-cycle pulse from controller: sub-op finished
weight_addr0_out..weight_addr3_out  out  AddrWidth each  lane weight addresses
data_addr0_out..data_addr3_out  out  AddrWidth each  lane data addresses
pict_size_out  out  PictWidth  picture size of current sub-op
conv_first_out  out  1  1 on first group of an instruction (start fresh accumulation)
inst_tag_out  out  1  toggles once per issued sub-op
busy_out  out  1  state != IDLE
inst_done_out  out  1  one-cycle pulse when last group of an instruction completes
fifo_level_out  out  FifoAw+1  entries currently buffered

Behaviour:
- Reset (Rst low, async): FIFO empty, level 0, state IDLE. All address outputs 0, pict_size_out 0, conv_first_out 0, inst_tag_out 0, busy_out 0, inst_done_out 0. inst_ready_out is 1 after reset.
- FIFO:
  - push on inst_valid_in&&inst_ready_out; pop only in state IDLE when not empty.
  - Simultaneous push and pop are both performed; level is unchanged.
  - Push when full is ignored (ready=0); pointers wrap mod FifoDepth.
  - Data is read from the head registered-free (combinational head), so pop and load occur in the same cycle.
- State machine:
  - IDLE: if FIFO not empty -> pop head, latch wbase/dbase/dstride/pict, groups_left=max(groups,1), set w_ptr=wbase, d_ptr=dbase, first=1; go LOAD.
  - LOAD (1 cycle): register outputs:
    - weight_addrK = w_ptr + K*KernelSize
    - data_addrK = d_ptr + K*dstride, K=0..3, computed by shift/add, no multiplier
    - pict_size_out=pict; conv_first_out=first
    - go ISSUE.
  - ISSUE (1 cycle): toggle inst_tag_out; go WAIT. Addresses and pict are stable from LOAD, so they are stable >=1 cycle before the tag edge and for the whole sub-op.
  - WAIT: hold all outputs.
    - On conv_done_in: groups_left-=1; w_ptr+=4*KernelSize; d_ptr+=4*dstride; first=0.
    - If groups_left was 1 -> pulse inst_done_out, go IDLE. Else go LOAD.
- conv_done_in is ignored in IDLE/LOAD/ISSUE (no counter change, no pulse).
- Arithmetic: all address sums are unsigned, modulo 2^AddrWidth (wrap silently).
- Latency:
  - Push to inst_tag toggle with FIFO empty and IDLE = 3 cycles: push edge, IDLE pop, LOAD, ISSUE.
  - conv_done_in to next tag toggle = 2 cycles (LOAD, ISSUE).
- Back-to-back instructions: after inst_done_out the next instruction is popped in the following IDLE cycle (1 bubble).
- Reset mid-operation: everything returns to reset values immediately; buffered instructions are discarded.

Test Plan:
1. Reset then idle -> all outputs 0, inst_ready_out=1, fifo_level_out=0, busy_out=0.
2. Single instruction: push wbase=0x100, dbase=0x2000, dstride=81, pict=9, groups=1 -> 3 cycles later inst_tag 0->1, weight_addr0..3=0x100,0x109,0x112,0x11B, data_addr0..3=0x2000,0x2051,0x20A2,0x20F3, conv_first=1. Pulse conv_done -> inst_done pulse, busy=0.
3. groups=3, same fields -> three tag toggles, each 2 cycles after a done pulse. Second sub-op weight_addr0=0x124, data_addr0=0x2144, conv_first=0. Third sub-op weight_addr0=0x148. Exactly one inst_done, after the third done pulse.
4. Push 5 instructions while the first is executing (depth 4) -> ready drops at level 4. The 5th is held by the source until a pop; all 5 execute in order, and tag toggles total = sum of groups.
5. conv_done_in pulsed in IDLE and during LOAD/ISSUE -> no state change, no inst_done; groups=0 behaves as 1.
6. Assert Rst low in WAIT with 2 entries buffered -> outputs 0 and level 0 asynchronously. After release, no tag toggle until a new push.

Source files
------------

// File: rtl/conv_inst_sched.sv
// Convolution instruction scheduler: buffers layer-level instructions in a small FIFO
// and expands each one into per-channel-group sub-ops for the convolution controller.
module conv_inst_sched #(
  parameter int AddrWidth  = 32,
  parameter int PictWidth  = 9,
  parameter int GroupWidth = 8,
  parameter int KernelSize = 9,
  parameter int InputDim   = 4,
  parameter int FifoDepth  = 4,
  parameter int FifoAw     = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  inst_valid_in,
  output logic                  inst_ready_out,
  input  logic [AddrWidth-1:0]  inst_wbase_in,
  input  logic [AddrWidth-1:0]  inst_dbase_in,
  input  logic [AddrWidth-1:0]  inst_dstride_in,
  input  logic [PictWidth-1:0]  inst_pict_in,
  input  logic [GroupWidth-1:0] inst_groups_in,
  input  logic                  conv_done_in,
  output logic [AddrWidth-1:0]  weight_addr0_out,
  output logic [AddrWidth-1:0]  weight_addr1_out,
  output logic [AddrWidth-1:0]  weight_addr2_out,
  output logic [AddrWidth-1:0]  weight_addr3_out,
  output logic [AddrWidth-1:0]  data_addr0_out,
  output logic [AddrWidth-1:0]  data_addr1_out,
  output logic [AddrWidth-1:0]  data_addr2_out,
  output logic [AddrWidth-1:0]  data_addr3_out,
  output logic [PictWidth-1:0]  pict_size_out,
  output logic                  conv_first_out,
  output logic                  inst_tag_out,
  output logic                  busy_out,
  output logic                  inst_done_out,
  output logic [FifoAw:0]       fifo_level_out
);

  localparam int                   LaneShift = $clog2(InputDim);
  localparam logic [AddrWidth-1:0] WStep     = AddrWidth'(InputDim * KernelSize);
  localparam logic [FifoAw:0]      LevelFull = (FifoAw+1)'(FifoDepth);
  localparam logic [FifoAw-1:0]    PtrOne    = FifoAw'(1);
  localparam logic [FifoAw:0]      LevelOne  = (FifoAw+1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, WAIT} state_e;

  typedef struct packed {
    logic [AddrWidth-1:0]  wbase;
    logic [AddrWidth-1:0]  dbase;
    logic [AddrWidth-1:0]  dstride;
    logic [PictWidth-1:0]  pict;
    logic [GroupWidth-1:0] groups;
  } inst_t;

  inst_t                 fifo_mem [FifoDepth];
  inst_t                 head;
  logic                  push, pop;

  state_e                state_q, state_d;
  logic [FifoAw-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FifoAw:0]       level_q, level_d;
  logic [AddrWidth-1:0]  w_ptr_q, w_ptr_d, d_ptr_q, d_ptr_d, dstride_q, dstride_d;
  logic [PictWidth-1:0]  pict_q, pict_d;
  logic [GroupWidth-1:0] groups_left_q, groups_left_d;
  logic                  first_q, first_d;
  logic [AddrWidth-1:0]  wa_q [4];
  logic [AddrWidth-1:0]  wa_d [4];
  logic [AddrWidth-1:0]  da_q [4];
  logic [AddrWidth-1:0]  da_d [4];
  logic [PictWidth-1:0]  pict_out_q, pict_out_d;
  logic                  conv_first_q, conv_first_d;
  logic                  tag_q, tag_d;
  logic                  done_q, done_d;

  assign inst_ready_out = (level_q != LevelFull);
  assign push           = inst_valid_in && inst_ready_out;
  assign head           = fifo_mem[rd_ptr_q];

  // NOTE: storage array carries no reset; the pointers and level alone define validity,
  // which keeps it a plain register file with no reset fan-out.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{wbase:   inst_wbase_in,
                              dbase:   inst_dbase_in,
                              dstride: inst_dstride_in,
                              pict:    inst_pict_in,
                              groups:  inst_groups_in};
    end
  end

  // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    w_ptr_d       = w_ptr_q;
    d_ptr_d       = d_ptr_q;
    dstride_d     = dstride_q;
    pict_d        = pict_q;
    groups_left_d = groups_left_q;
    first_d       = first_q;
    wa_d          = wa_q;
    da_d          = da_q;
    pict_out_d    = pict_out_q;
    conv_first_d  = conv_first_q;
    tag_d         = tag_q;
    done_d        = 1'b0;
    pop           = 1'b0;

    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop           = 1'b1;
          w_ptr_d       = head.wbase;
          d_ptr_d       = head.dbase;
          dstride_d     = head.dstride;
          pict_d        = head.pict;
          groups_left_d = (head.groups == '0) ? GroupWidth'(1) : head.groups;
          first_d       = 1'b1;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        for (int k = 0; k < 4; k++) begin
          wa_d[k] = w_ptr_q + AddrWidth'(k * KernelSize);
        end
        // Lane data offsets 0, s, 2s, 3s built from shifts and adds only.
        da_d[0]      = d_ptr_q;
        da_d[1]      = d_ptr_q + dstride_q;
        da_d[2]      = d_ptr_q + (dstride_q << 1);
        da_d[3]      = d_ptr_q + (dstride_q << 1) + dstride_q;
        pict_out_d   = pict_q;
        conv_first_d = first_q;
        state_d      = ISSUE;
      end
      ISSUE: begin
        tag_d   = ~tag_q;
        state_d = WAIT;
      end
      WAIT: begin
        if (conv_done_in) begin
          groups_left_d = groups_left_q - GroupWidth'(1);
          w_ptr_d       = w_ptr_q + WStep;
          d_ptr_d       = d_ptr_q + (dstride_q << LaneShift);
          first_d       = 1'b0;
          if (groups_left_q == GroupWidth'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      w_ptr_q       <= '0;
      d_ptr_q       <= '0;
      dstride_q     <= '0;
      pict_q        <= '0;
      groups_left_q <= '0;
      first_q       <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        wa_q[k] <= '0;
        da_q[k] <= '0;
      end
      pict_out_q    <= '0;
      conv_first_q  <= 1'b0;
      tag_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      w_ptr_q       <= w_ptr_d;
      d_ptr_q       <= d_ptr_d;
      dstride_q     <= dstride_d;
      pict_q        <= pict_d;
      groups_left_q <= groups_left_d;
      first_q       <= first_d;
      wa_q          <= wa_d;
      da_q          <= da_d;
      pict_out_q    <= pict_out_d;
      conv_first_q  <= conv_first_d;
      tag_q         <= tag_d;
      done_q        <= done_d;
    end
  end

  assign weight_addr0_out = wa_q[0];
  assign weight_addr1_out = wa_q[1];
  assign weight_addr2_out = wa_q[2];
  assign weight_addr3_out = wa_q[3];
  assign data_addr0_out   = da_q[0];
  assign data_addr1_out   = da_q[1];
  assign data_addr2_out   = da_q[2];
  assign data_addr3_out   = da_q[3];
  assign pict_size_out    = pict_out_q;
  assign conv_first_out   = conv_first_q;
  assign inst_tag_out     = tag_q;
  assign busy_out         = (state_q != IDLE);
  assign inst_done_out    = done_q;
  assign fifo_level_out   = level_q;

endmodule

// File: tb/tb_conv_inst_sched.sv
// Self-checking bench for conv_inst_sched: directed vector table, hand-written corner
// sequences and randomized instructions checked against an arithmetic sub-op model.
module tb_conv_inst_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [31:0] wbase = '0, dbase = '0, dstride = '0;
  logic [8:0]  pict = '0;
  logic [7:0]  groups = '0;
  logic        conv_done = 1'b0;
  logic [31:0] w0, w1, w2, w3, d0, d1, d2, d3;
  logic [8:0]  pict_o;
  logic        first_o, tag_o, busy_o, done_o;
  logic [2:0]  level_o;
  logic [31:0] wa [4];
  logic [31:0] da [4];

  int n_tests = 0;
  int n_fail  = 0;
  bit tag_exp = 1'b0;
  int tog_cnt = 0;
  logic tag_prev = 1'b0;

  always #5 clk = ~clk;

  conv_inst_sched dut (
    .Clk(clk), .Rst(rst_n),
    .inst_valid_in(inst_valid), .inst_ready_out(inst_ready),
    .inst_wbase_in(wbase), .inst_dbase_in(dbase), .inst_dstride_in(dstride),
    .inst_pict_in(pict), .inst_groups_in(groups), .conv_done_in(conv_done),
    .weight_addr0_out(w0), .weight_addr1_out(w1), .weight_addr2_out(w2), .weight_addr3_out(w3),
    .data_addr0_out(d0), .data_addr1_out(d1), .data_addr2_out(d2), .data_addr3_out(d3),
    .pict_size_out(pict_o), .conv_first_out(first_o), .inst_tag_out(tag_o),
    .busy_out(busy_o), .inst_done_out(done_o), .fifo_level_out(level_o)
  );

  always_comb begin
    wa[0] = w0; wa[1] = w1; wa[2] = w2; wa[3] = w3;
    da[0] = d0; da[1] = d1; da[2] = d2; da[3] = d3;
  end

  // Independent toggle counter on the tag line.
  always @(negedge clk) begin
    if (tag_o !== tag_prev) tog_cnt++;
    tag_prev = tag_o;
  end

  typedef struct {
    logic [31:0] wbase, dbase, dstride;
    logic [8:0]  pict;
    logic [7:0]  groups;
  } instr_t;

  typedef struct {
    logic [31:0] w [4];
    logic [31:0] d [4];
    logic [8:0]  pict;
    bit          first, last;
  } sub_t;

  typedef struct {
    instr_t      in;
    logic [31:0] w [4];
    logic [31:0] d [4];
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int n_groups(input instr_t i);
    return (i.groups == 0) ? 1 : int'(i.groups);
  endfunction

  // Sub-op g covers channels 4g..4g+3; channel c sits at wbase+9c and dbase+c*dstride.
  function automatic sub_t model(input instr_t i, input int g);
    sub_t r;
    for (int k = 0; k < 4; k++) begin
      r.w[k] = i.wbase + 32'(9 * (4 * g + k));
      r.d[k] = i.dbase + i.dstride * 32'(4 * g + k);
    end
    r.pict  = i.pict;
    r.first = (g == 0);
    r.last  = (g == n_groups(i) - 1);
    return r;
  endfunction

  task automatic check_reset(input string nm);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s w%0d", nm, k), wa[k], 0);
      check($sformatf("%s d%0d", nm, k), da[k], 0);
    end
    check({nm, " pict"},  pict_o, 0);
    check({nm, " first"}, first_o, 0);
    check({nm, " tag"},   tag_o, 0);
    check({nm, " busy"},  busy_o, 0);
    check({nm, " done"},  done_o, 0);
    check({nm, " ready"}, inst_ready, 1);
    check({nm, " level"}, level_o, 0);
  endtask

  task automatic push(input instr_t i);
    int n = 0;
    @(negedge clk);
    inst_valid = 1'b1;
    wbase = i.wbase; dbase = i.dbase; dstride = i.dstride; pict = i.pict; groups = i.groups;
    while (!inst_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("push ready", inst_ready, 1);
    @(posedge clk);
    @(negedge clk);
    inst_valid = 1'b0;
  endtask

  // Waits for the tag edge, checks the issued sub-op, then acts as the controller.
  task automatic serve_one(input sub_t e, input string nm, output int lat);
    int n = 0;
    while (tag_o == tag_exp && n < 60) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    check({nm, " tag"}, tag_o, !tag_exp);
    tag_exp = !tag_exp;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s w%0d", nm, k), wa[k], e.w[k]);
      check($sformatf("%s d%0d", nm, k), da[k], e.d[k]);
    end
    check({nm, " pict"},  pict_o, e.pict);
    check({nm, " first"}, first_o, e.first);
    check({nm, " busy"},  busy_o, 1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check({nm, " hold w0"}, w0, e.w[0]);
    check({nm, " early done"}, done_o, 0);
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    check({nm, " inst_done"}, done_o, e.last);
    if (e.last) check({nm, " idle after"}, busy_o, 0);
  endtask

  task automatic serve_instr(input instr_t i, input string nm);
    int lat;
    for (int g = 0; g < n_groups(i); g++) begin
      serve_one(model(i, g), $sformatf("%s g%0d", nm, g), lat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs [4];
    instr_t i0, i5;
    instr_t extra [5];
    int     lat, total;

    // Test 1: reset.
    repeat (2) @(negedge clk);
    check_reset("in reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("after reset");

    // Tests 2/3 and boundaries: directed vector table.
    vecs[0].in = '{32'h100, 32'h2000, 32'd81, 9'd9, 8'd1};
    vecs[0].w  = '{32'h100, 32'h109, 32'h112, 32'h11B};
    vecs[0].d  = '{32'h2000, 32'h2051, 32'h20A2, 32'h20F3};
    vecs[1].in = '{32'h100, 32'h2000, 32'd81, 9'd9, 8'd3};
    vecs[1].w  = '{32'h100, 32'h109, 32'h112, 32'h11B};
    vecs[1].d  = '{32'h2000, 32'h2051, 32'h20A2, 32'h20F3};
    vecs[2].in = '{32'h0, 32'h0, 32'd1, 9'd1, 8'd0};
    vecs[2].w  = '{32'd0, 32'd9, 32'd18, 32'd27};
    vecs[2].d  = '{32'd0, 32'd1, 32'd2, 32'd3};
    vecs[3].in = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h8000_0000, 9'd511, 8'd2};
    vecs[3].w  = '{32'hFFFF_FFF0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_000B};
    vecs[3].d  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

    for (int v = 0; v < 4; v++) begin
      push(vecs[v].in);
      for (int g = 0; g < n_groups(vecs[v].in); g++) begin
        sub_t e;
        e = model(vecs[v].in, g);
        if (g == 0) begin
          e.w = vecs[v].w;
          e.d = vecs[v].d;
        end
        serve_one(e, $sformatf("vec%0d g%0d", v, g), lat);
        check($sformatf("vec%0d g%0d latency", v, g), lat, (g == 0) ? 3 : 2);
      end
    end

    // Test 5: conv_done ignored in IDLE, LOAD and ISSUE; groups=0 runs once.
    @(negedge clk);
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    check("idle done: inst_done", done_o, 0);
    check("idle done: busy", busy_o, 0);
    check("idle done: tag", tag_o, tag_exp);
    i0 = '{32'h40, 32'h80, 32'd5, 9'd3, 8'd0};
    push(i0);
    conv_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("early done: inst_done", done_o, 0);
    end
    conv_done = 1'b0;
    serve_instr(i0, "g0 inst");
    repeat (4) @(negedge clk);
    check("g0 inst: no extra issue", tag_o, tag_exp);

    // Test 4: fill the FIFO behind a running instruction, random contents.
    i0 = '{32'h4000, 32'h8000, 32'd16, 9'd32, 8'd4};
    total = 4;
    for (int j = 0; j < 5; j++) begin
      extra[j].wbase   = $urandom();
      extra[j].dbase   = $urandom();
      extra[j].dstride = $urandom();
      extra[j].pict    = 9'($urandom_range(0, 511));
      extra[j].groups  = 8'($urandom_range(0, 3));
      total += n_groups(extra[j]);
    end
    tog_cnt = 0;
    push(i0);
    fork
      begin
        for (int j = 0; j < 5; j++) begin
          push(extra[j]);
          if (j == 3) begin
            check("fifo full level", level_o, 4);
            check("fifo full ready", inst_ready, 0);
          end
        end
      end
      begin
        serve_instr(i0, "burst0");
        for (int j = 0; j < 5; j++) serve_instr(extra[j], $sformatf("burst%0d", j + 1));
      end
    join
    repeat (4) @(negedge clk);
    check("burst toggle total", tog_cnt, total);
    check("burst drained level", level_o, 0);

    // Test 6: asynchronous reset in WAIT with two entries buffered.
    i0 = '{32'h1000, 32'h3000, 32'd7, 9'd12, 8'd2};
    push(i0);
    push(i0);
    push(i0);
    begin
      int n = 0;
      while (tag_o == tag_exp && n < 60) begin
        @(negedge clk);
        n++;
      end
    end
    check("pre-reset busy", busy_o, 1);
    check("pre-reset level", level_o, 2);
    #2 rst_n = 1'b0;
    #1 check_reset("async reset");
    tag_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post-reset tag", tag_o, 0);
    check("post-reset busy", busy_o, 0);
    check("post-reset level", level_o, 0);
    i5 = '{32'h500, 32'h600, 32'd3, 9'd4, 8'd1};
    push(i5);
    serve_instr(i5, "recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
